// File: rtl/zap_cp15_pkg.sv
// Shared CP15 responder definitions: FSM encoding, CRn numbers, instruction
// field positions and the banked register-index translation.
package zap_cp15_pkg;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StDecode   = 3'd1;
  localparam logic [2:0] StMcrWb    = 3'd2;
  localparam logic [2:0] StDone     = 3'd3;
  localparam logic [2:0] StWaitDrop = 3'd4;

  localparam logic [3:0] C0_ID    = 4'd0;
  localparam logic [3:0] C1_CTRL  = 4'd1;
  localparam logic [3:0] C2_TTB   = 4'd2;
  localparam logic [3:0] C3_DAC   = 4'd3;
  localparam logic [3:0] C5_FSR   = 4'd5;
  localparam logic [3:0] C6_FAR   = 4'd6;
  localparam logic [3:0] C7_CACHE = 4'd7;
  localparam logic [3:0] C8_TLB   = 4'd8;

  localparam int unsigned LBit   = 20;
  localparam int unsigned CrnLsb = 16;
  localparam int unsigned RdLsb  = 12;
  localparam int unsigned CpLsb  = 8;
  localparam int unsigned OpLsb  = 24;
  localparam int unsigned XfrBit = 4;

  localparam logic [3:0] CoproXfrOp = 4'b1110;
  localparam logic [3:0] Cp15       = 4'hF;
  localparam logic [3:0] RegPc      = 4'hF;

  localparam logic [4:0] ModeUsr = 5'h10;
  localparam logic [4:0] ModeFiq = 5'h11;
  localparam logic [4:0] ModeIrq = 5'h12;
  localparam logic [4:0] ModeSvc = 5'h13;
  localparam logic [4:0] ModeAbt = 5'h17;
  localparam logic [4:0] ModeUnd = 5'h1B;
  localparam logic [4:0] ModeSys = 5'h1F;

  // Physical layout: 0..15 user/system R0..R15, then the banked copies.
  localparam int unsigned PhyFiqBase = 16;  // R8_fiq..R14_fiq
  localparam int unsigned PhyIrqBase = 23;  // R13_irq, R14_irq
  localparam int unsigned PhySvcBase = 25;
  localparam int unsigned PhyAbtBase = 27;
  localparam int unsigned PhyUndBase = 29;

  function automatic int unsigned translate(input logic [3:0] rd, input logic [4:0] mode);
    int unsigned r;
    int unsigned idx;
    r   = 32'(rd);
    idx = r;
    case (mode)
      ModeFiq: if (r >= 32'd8 && r <= 32'd14) idx = PhyFiqBase + r - 32'd8;
      ModeIrq: if (r >= 32'd13 && r <= 32'd14) idx = PhyIrqBase + r - 32'd13;
      ModeSvc: if (r >= 32'd13 && r <= 32'd14) idx = PhySvcBase + r - 32'd13;
      ModeAbt: if (r >= 32'd13 && r <= 32'd14) idx = PhyAbtBase + r - 32'd13;
      ModeUnd: if (r >= 32'd13 && r <= 32'd14) idx = PhyUndBase + r - 32'd13;
      default: ;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/zap_cp15_responder_if.sv
// Predecode coprocessor handshake plus the dedicated register-file port.
interface zap_cp15_responder_if #(
  parameter int unsigned IdxW = 6
) ();

  logic            copro_dav;
  logic [31:0]     copro_word;
  logic            copro_done;
  logic            unsupported;
  logic            reg_rd_en;
  logic [IdxW-1:0] reg_rd_index;
  logic [31:0]     reg_rd_data;
  logic            reg_wr_en;
  logic [IdxW-1:0] reg_wr_index;
  logic [31:0]     reg_wr_data;

  modport master (
    output copro_dav, copro_word, reg_rd_data,
    input  copro_done, unsupported, reg_rd_en, reg_rd_index,
    input  reg_wr_en, reg_wr_index, reg_wr_data
  );

  modport slave (
    input  copro_dav, copro_word, reg_rd_data,
    output copro_done, unsupported, reg_rd_en, reg_rd_index,
    output reg_wr_en, reg_wr_index, reg_wr_data
  );

endinterface

// File: rtl/zap_cp15_regfile.sv
// CP15 register storage, read mux, data-abort capture and invalidate pulses.
module zap_cp15_regfile
  import zap_cp15_pkg::*;
#(
  parameter logic [31:0] CP_ID = 32'h4107_9000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        wr_en_i,
  input  logic [3:0]  crn_i,
  input  logic [31:0] wr_data_i,
  input  logic        fault_valid_i,
  input  logic [7:0]  fsr_i,
  input  logic [31:0] far_i,
  output logic [31:0] rd_data_o,
  output logic [31:0] control_o,
  output logic [31:0] ttb_o,
  output logic [31:0] dac_o,
  output logic        cache_inv_o,
  output logic        tlb_inv_o
);

  logic [31:0] control_q, control_d;
  logic [31:0] ttb_q, ttb_d;
  logic [31:0] dac_q, dac_d;
  logic [7:0]  fsr_q, fsr_d;
  logic [31:0] far_q, far_d;

  always_comb begin
    control_d = control_q;
    ttb_d     = ttb_q;
    dac_d     = dac_q;
    fsr_d     = fsr_q;
    far_d     = far_q;
    if (wr_en_i) begin
      case (crn_i)
        C1_CTRL: control_d = wr_data_i;
        C2_TTB:  ttb_d     = wr_data_i;
        C3_DAC:  dac_d     = wr_data_i;
        C5_FSR:  fsr_d     = wr_data_i[7:0];
        C6_FAR:  far_d     = wr_data_i;
        default: ;
      endcase
    end
    // A data abort outranks a same-cycle MCR to c5/c6.
    if (fault_valid_i) begin
      fsr_d = fsr_i;
      far_d = far_i;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      control_q <= '0;
      ttb_q     <= '0;
      dac_q     <= '0;
      fsr_q     <= '0;
      far_q     <= '0;
    end else begin
      control_q <= control_d;
      ttb_q     <= ttb_d;
      dac_q     <= dac_d;
      fsr_q     <= fsr_d;
      far_q     <= far_d;
    end
  end

  always_comb begin
    rd_data_o = '0;
    case (crn_i)
      C0_ID:   rd_data_o = CP_ID;
      C1_CTRL: rd_data_o = control_q;
      C2_TTB:  rd_data_o = ttb_q;
      C3_DAC:  rd_data_o = dac_q;
      C5_FSR:  rd_data_o = {24'h0, fsr_q};
      C6_FAR:  rd_data_o = far_q;
      default: rd_data_o = '0;
    endcase
  end

  assign control_o   = control_q;
  assign ttb_o       = ttb_q;
  assign dac_o       = dac_q;
  assign cache_inv_o = wr_en_i && (crn_i == C7_CACHE);
  assign tlb_inv_o   = wr_en_i && (crn_i == C8_TLB);

endmodule

// File: rtl/zap_cp15_responder.sv
// CP15 responder: latches the held coprocessor word, runs MCR/MRC against the
// CP15 register file over the register-file port and pulses done once.
module zap_cp15_responder
  import zap_cp15_pkg::*;
#(
  parameter int unsigned PHY_REGS = 46,
  parameter logic [31:0] CP_ID    = 32'h4107_9000
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  zap_cp15_responder_if.slave        copro_if,
  input  logic [31:0]                cpsr_i,
  input  logic                       fault_valid_i,
  input  logic [7:0]                 fsr_i,
  input  logic [31:0]                far_i,
  output logic [31:0]                control_o,
  output logic [31:0]                ttb_o,
  output logic [31:0]                dac_o,
  output logic                       cache_inv_o,
  output logic                       tlb_inv_o
);

  localparam int unsigned IdxW = $clog2(PHY_REGS);

  logic [2:0]      state_q, state_d;
  logic [31:0]     instr_q, instr_d;
  logic            is_mrc;
  logic [3:0]      crn;
  logic [3:0]      rd;
  logic [3:0]      cpn;
  logic            valid;
  logic [IdxW-1:0] reg_idx;
  logic [31:0]     cp_rdata;
  logic            mcr_commit;

  assign is_mrc = instr_q[LBit];
  assign crn    = instr_q[CrnLsb +: 4];
  assign rd     = instr_q[RdLsb +: 4];
  assign cpn    = instr_q[CpLsb +: 4];
  assign valid  = (instr_q[OpLsb +: 4] == CoproXfrOp) && instr_q[XfrBit] && (cpn == Cp15) &&
                  !(is_mrc && (rd == RegPc));

  assign reg_idx = IdxW'(translate(rd, cpsr_i[4:0]));

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      StIdle: begin
        if (copro_if.copro_dav) begin
          instr_d = copro_if.copro_word;
          state_d = StDecode;
        end
      end
      StDecode:   state_d = (valid && !is_mrc) ? StMcrWb : StDone;
      StMcrWb:    state_d = StDone;
      StDone:     state_d = StWaitDrop;
      // Hold off until dav drops so a still-held word is not executed twice.
      StWaitDrop: if (!copro_if.copro_dav) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= StIdle;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    copro_if.reg_rd_en    = 1'b0;
    copro_if.reg_rd_index = '0;
    copro_if.reg_wr_en    = 1'b0;
    copro_if.reg_wr_index = '0;
    copro_if.reg_wr_data  = '0;
    if ((state_q == StDecode) && valid) begin
      if (is_mrc) begin
        copro_if.reg_wr_en    = 1'b1;
        copro_if.reg_wr_index = reg_idx;
        copro_if.reg_wr_data  = cp_rdata;
      end else begin
        copro_if.reg_rd_en    = 1'b1;
        copro_if.reg_rd_index = reg_idx;
      end
    end
    copro_if.copro_done  = (state_q == StDone);
    copro_if.unsupported = (state_q == StDone) && !valid;
  end

  // MCR_WB is only entered for a valid MCR.
  assign mcr_commit = (state_q == StMcrWb);

  zap_cp15_regfile #(
    .CP_ID(CP_ID)
  ) u_regfile (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .wr_en_i      (mcr_commit),
    .crn_i        (crn),
    .wr_data_i    (copro_if.reg_rd_data),
    .fault_valid_i(fault_valid_i),
    .fsr_i        (fsr_i),
    .far_i        (far_i),
    .rd_data_o    (cp_rdata),
    .control_o    (control_o),
    .ttb_o        (ttb_o),
    .dac_o        (dac_o),
    .cache_inv_o  (cache_inv_o),
    .tlb_inv_o    (tlb_inv_o)
  );

  logic unused_bits;
  assign unused_bits = ^{instr_q[31:28], instr_q[23:21], instr_q[7:5], instr_q[3:0],
                         cpsr_i[31:5]};

endmodule

// File: tb/tb_zap_cp15_responder.sv
// Directed bench for zap_cp15_responder; expected bus events are queued when a
// word is issued and matched in order as the DUT produces them.
module tb_zap_cp15_responder;
  import zap_cp15_pkg::*;

  localparam logic [31:0] CpId = 32'h4107_9000;
  localparam int KRd   = 1;
  localparam int KWr   = 2;
  localparam int KInv  = 3;
  localparam int KDone = 4;
  localparam int OpMcr = 0;
  localparam int OpMrc = 1;
  localparam int OpUns = 2;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] cyc;
    logic [7:0]  idx;
    logic [31:0] data;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [31:0] cpsr;
  logic        fault_valid;
  logic [7:0]  fsr;
  logic [31:0] far;
  logic [31:0] control;
  logic [31:0] ttb;
  logic [31:0] dac;
  logic        cache_inv;
  logic        tlb_inv;
  logic [31:0] arf [46];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  ev_t         exp_q[$];

  zap_cp15_responder_if #(.IdxW(6)) bus ();

  zap_cp15_responder #(
    .PHY_REGS(46),
    .CP_ID   (CpId)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .copro_if     (bus),
    .cpsr_i       (cpsr),
    .fault_valid_i(fault_valid),
    .fsr_i        (fsr),
    .far_i        (far),
    .control_o    (control),
    .ttb_o        (ttb),
    .dac_o        (dac),
    .cache_inv_o  (cache_inv),
    .tlb_inv_o    (tlb_inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ARM register file model: read data returns the cycle after the request.
  always @(posedge clk) bus.reg_rd_data <= bus.reg_rd_en ? arf[bus.reg_rd_index] : 32'h0;

  function automatic ev_t mk_ev(input int k, input int c, input int i, input logic [31:0] d);
    ev_t e;
    e.kind = 3'(k);
    e.cyc  = 32'(c);
    e.idx  = 8'(i);
    e.data = d;
    return e;
  endfunction

  function automatic logic [31:0] cp_word(input logic l, input logic [3:0] crn,
                                          input logic [3:0] rd, input logic [3:0] cp);
    return {4'hE, 4'hE, 3'b000, l, crn, rd, cp, 3'b000, 1'b1, 4'h0};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_ev(input ev_t obs);
    ev_t exp;
    exp = '0;
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL event: got kind=%0d cyc=%0d idx=%0d data=%h want kind=%0d cyc=%0d idx=%0d data=%h",
             obs.kind, obs.cyc, obs.idx, obs.data, exp.kind, exp.cyc, exp.idx, exp.data);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.reg_rd_en === 1'b1) check_ev(mk_ev(KRd, cyc, int'(bus.reg_rd_index), 32'h0));
      if (bus.reg_wr_en === 1'b1)
        check_ev(mk_ev(KWr, cyc, int'(bus.reg_wr_index), bus.reg_wr_data));
      if ((cache_inv | tlb_inv) === 1'b1)
        check_ev(mk_ev(KInv, cyc, 0, {30'h0, tlb_inv, cache_inv}));
      if (bus.copro_done === 1'b1) check_ev(mk_ev(KDone, cyc, 0, {31'h0, bus.unsupported}));
    end
  end

  // Issue one word, queue its expected events, hold dav for `hold` cycles.
  task automatic issue(input logic [31:0] w, input logic [4:0] mode, input int op,
                       input int idx, input logic [31:0] data, input logic [1:0] inv,
                       input int hold, input int fault_at);
    int t;
    @(posedge clk); #1;
    t = cyc;
    case (op)
      OpMcr: begin
        exp_q.push_back(mk_ev(KRd, t + 1, idx, 32'h0));
        if (inv != 2'b00) exp_q.push_back(mk_ev(KInv, t + 2, 0, {30'h0, inv}));
        exp_q.push_back(mk_ev(KDone, t + 3, 0, 32'h0));
      end
      OpMrc: begin
        exp_q.push_back(mk_ev(KWr, t + 1, idx, data));
        exp_q.push_back(mk_ev(KDone, t + 2, 0, 32'h0));
      end
      default: exp_q.push_back(mk_ev(KDone, t + 2, 0, 32'h1));
    endcase
    cpsr = {27'h0, mode};
    bus.copro_word = w;
    bus.copro_dav  = 1'b1;
    for (int k = 1; k <= hold; k++) begin
      @(posedge clk); #1;
      fault_valid = (k == fault_at);
    end
    fault_valid   = 1'b0;
    bus.copro_dav = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int t;
    rst = 1'b1;
    cpsr = {27'h0, ModeUsr};
    fault_valid = 1'b0;
    fsr = 8'h00;
    far = 32'h0;
    bus.copro_dav = 1'b0;
    bus.copro_word = 32'h0;
    for (int i = 0; i < 46; i++) arf[i] = 32'h5A00_0000 + 32'(i);
    arf[3]  = 32'hDEAD_0000;
    arf[2]  = 32'hCAFE_F00D;
    arf[4]  = 32'hFFFF_FFAA;
    arf[21] = 32'h1111_0021;
    arf[25] = 32'h2222_0025;
    repeat (3) @(posedge clk);
    #1;
    check("rst_control", control, 32'h0);
    check("rst_ttb", ttb, 32'h0);
    check("rst_dac", dac, 32'h0);
    check("rst_done", {31'h0, bus.copro_done}, 32'h0);
    check("rst_rd_en", {31'h0, bus.reg_rd_en}, 32'h0);
    check("rst_wr_en", {31'h0, bus.reg_wr_en}, 32'h0);
    check("rst_inv", {30'h0, tlb_inv, cache_inv}, 32'h0);
    rst = 1'b0;

    issue(cp_word(1'b0, 4'd2, 4'd3, 4'hF), ModeUsr, OpMcr, 3, 32'h0, 2'b00, 5, 0);
    check("ttb_after_mcr", ttb, 32'hDEAD_0000);
    issue(cp_word(1'b1, 4'd2, 4'd5, 4'hF), ModeUsr, OpMrc, 5, 32'hDEAD_0000, 2'b00, 5, 0);
    issue(cp_word(1'b1, 4'd0, 4'd0, 4'hF), ModeUsr, OpMrc, 0, CpId, 2'b00, 5, 0);
    issue(cp_word(1'b0, 4'd2, 4'd3, 4'hE), ModeUsr, OpUns, 0, 32'h0, 2'b00, 10, 0);
    issue(cp_word(1'b1, 4'd1, 4'hF, 4'hF), ModeUsr, OpUns, 0, 32'h0, 2'b00, 5, 0);

    issue(cp_word(1'b0, 4'd5, 4'd4, 4'hF), ModeUsr, OpMcr, 4, 32'h0, 2'b00, 5, 0);
    issue(cp_word(1'b1, 4'd5, 4'd6, 4'hF), ModeUsr, OpMrc, 6, 32'h0000_00AA, 2'b00, 5, 0);
    fsr = 8'h05;
    far = 32'h1234_5678;
    issue(cp_word(1'b0, 4'd5, 4'd4, 4'hF), ModeUsr, OpMcr, 4, 32'h0, 2'b00, 5, 2);
    issue(cp_word(1'b1, 4'd5, 4'd6, 4'hF), ModeUsr, OpMrc, 6, 32'h0000_0005, 2'b00, 5, 0);
    issue(cp_word(1'b1, 4'd6, 4'd7, 4'hF), ModeUsr, OpMrc, 7, 32'h1234_5678, 2'b00, 5, 0);

    issue(cp_word(1'b0, 4'd8, 4'd0, 4'hF), ModeUsr, OpMcr, 0, 32'h0, 2'b10, 5, 0);
    issue(cp_word(1'b0, 4'd7, 4'd1, 4'hF), ModeUsr, OpMcr, 1, 32'h0, 2'b01, 5, 0);
    issue(cp_word(1'b0, 4'd1, 4'd2, 4'hF), ModeUsr, OpMcr, 2, 32'h0, 2'b00, 5, 0);
    check("control_set", control, 32'hCAFE_F00D);

    // Reset lands while the MCR sits in its write-back cycle.
    @(posedge clk); #1;
    t = cyc;
    exp_q.push_back(mk_ev(KRd, t + 1, 3, 32'h0));
    bus.copro_word = cp_word(1'b0, 4'd1, 4'd3, 4'hF);
    bus.copro_dav  = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.copro_dav = 1'b0;
    check("state_after_reset", 32'(dut.state_q), 32'(StIdle));
    repeat (4) @(posedge clk);
    #1;
    check("control_after_reset", control, 32'h0);
    check("ttb_after_reset", ttb, 32'h0);

    issue(cp_word(1'b0, 4'd3, 4'd13, 4'hF), ModeFiq, OpMcr, 21, 32'h0, 2'b00, 5, 0);
    check("dac_fiq_r13", dac, 32'h1111_0021);
    issue(cp_word(1'b0, 4'd3, 4'd13, 4'hF), ModeSvc, OpMcr, 25, 32'h0, 2'b00, 5, 0);
    check("dac_svc_r13", dac, 32'h2222_0025);

    repeat (5) @(posedge clk);
    #1;
    check("events_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zap_cp15_responder.md
# zap_cp15_responder

Coprocessor-15 responder for the ZAP core. It is the far end of the predecode coprocessor interface. It accepts the held coprocessor word while `copro_dav` is high and executes MCR/MRC against a small CP15 register file. MCR reads the ARM source register and MRC writes the ARM destination register, both over a dedicated register-file port. It completes each transfer with a single-cycle `copro_done` pulse, which releases the predecode stall.

## Interface
- `PHY_REGS`, 46: number of physical registers. The index width is `$clog2(PHY_REGS)`.
- `CP_ID`, 32'h4107_9000: read-only value returned for c0.
- `i_clk` in 1: clock.
- `i_reset` in 1: reset, synchronous, active-high; clock `i_clk`.
- `i_copro_dav` in 1: coprocessor word valid. It is held high until done.
- `i_copro_word` in 32: coprocessor instruction. It is stable while dav is high.
- `i_cpsr` in 32: current CPSR. Bits [4:0] select the register bank.
- `o_copro_done` out 1: single-cycle completion pulse.
- `o_reg_rd_en` out 1: register read request. Data returns on the next cycle.
- `o_reg_rd_index` out `$clog2(PHY_REGS)`: physical read index.
- `i_reg_rd_data` in 32: read data, valid the cycle after `o_reg_rd_en`.
- `o_reg_wr_en` out 1: register write strobe.
- `o_reg_wr_index` out `$clog2(PHY_REGS)`: physical write index.
- `o_reg_wr_data` out 32: write data.
- `i_fault_valid` in 1: data-abort capture strobe.
- `i_fsr` in 8: fault status to capture.
- `i_far` in 32: fault address to capture.
- `o_control` out 32: c1 contents.
- `o_ttb` out 32: c2 contents.
- `o_dac` out 32: c3 contents.
- `o_cache_inv` out 1: one-cycle pulse on any MCR to c7.
- `o_tlb_inv` out 1: one-cycle pulse on any MCR to c8.
- `o_unsupported` out 1: one-cycle pulse, raised for a rejected word together with `o_copro_done`.

## Operation
- Word decode of the latched copy `instr_ff`:
  - L = [20] (1 = MRC)
  - CRn = [19:16]
  - Rd = [15:12]
  - cp# = [11:8]
- Valid MCR/MRC requires [27:24] = 4'b1110, [4] = 1, and cp# = 15.
- Anything else is unsupported: CDP, LDC/STC, cp# ≠ 15, or MRC with Rd = 15. An unsupported word has no side effect, and the responder still pulses done.
- Physical index = translate(Rd, `i_cpsr`[4:0]). This is the banked mapping from the shared package. It is evaluated in DECODE.
- CP15 register map:
  - c0: reads `CP_ID`; writes are ignored.
  - c1, c2, c3: read/write.
  - c5: holds FSR in [7:0]; upper bits read 0.
  - c6: holds FAR.
  - c7, c8: write-only; each write produces its invalidate pulse.
  - All other CRn: read 0, writes ignored.
- FSM states:
  - IDLE: when dav = 1, latch `i_copro_word` into `instr_ff` and go to DECODE.
  - DECODE:
    - Valid MCR: assert `o_reg_rd_en` with the index, then go to MCR_WB.
    - Valid MRC: assert `o_reg_wr_en`, `o_reg_wr_index` and `o_reg_wr_data` (the CP register mux), then go to DONE.
    - Unsupported: go to DONE with the unsupported flag set.
  - MCR_WB: write `i_reg_rd_data` into CRn and fire the c7/c8 pulse, then go to DONE.
  - DONE: `o_copro_done` = 1 (plus `o_unsupported` if flagged), then go to WAIT_DROP.
  - WAIT_DROP: stay until dav = 0, then go to IDLE. This prevents re-executing a word that is still held.
- `o_reg_*`, done and pulse outputs are Moore outputs decoded from state and `instr_ff` only.
- Fault capture: `i_fault_valid` writes c5 and c6 in any state. If an MCR to c5/c6 commits in the same cycle, the fault wins and the MCR data is discarded; done is still pulsed.
- Reset values:
  - State: IDLE.
  - c1, c2, c3, c5, c6: 0.
  - All outputs: 0.
- Reset mid-operation aborts the transfer: no done pulse and no register write.

## Timing
- dav is first seen high in cycle T:
  - MRC: write strobe at T+1, done at T+2.
  - MCR: read request at T+1, CP register update at the T+2 edge, done at T+3.
  - Unsupported: done and `o_unsupported` at T+2.
- `o_control`, `o_ttb` and `o_dac` show new values from the cycle after MCR_WB.
- Done is exactly one cycle wide. The next transfer is accepted no earlier than one cycle after dav falls.
- If dav drops before DONE (protocol violation), the transfer still completes and done still pulses once.

## Structure
- Shared package `zap_cp15_pkg` holds:
  - State encoding.
  - CRn constants (C0_ID … C8_TLB).
  - Instruction field positions.
  - The mode `translate()` function.
- Natural sub-module: `zap_cp15_regfile`. It holds the CRn storage, the read mux, the fault capture and the invalidate pulses. The FSM lives in the top level.

## Test plan
- MCR p15,0,R3,c2,c0 with R3 = 32'hDEAD_0000 → read index 3 at T+1, `o_ttb` = 32'hDEAD_0000 and done at T+3, exactly one done pulse.
- After that MCR, MRC p15,0,R5,c2,c0 in user mode → write index 5, data 32'hDEAD_0000 at T+1, done at T+2. MRC of c0 → `CP_ID`.
- cp# = 14 word → no register access, done and `o_unsupported` at T+2. dav held for 10 cycles → no second done.
- MCR to c5 with `i_fault_valid` = 1 and `i_fsr` = 8'h05 on the commit cycle → c5 reads 32'h05.
- MCR to c8 → `o_tlb_inv` pulses one cycle. `i_reset` asserted in MCR_WB → no done, `o_control` = 0, FSM in IDLE.
- MCR R13 in FIQ mode vs. SVC mode → read indices differ per the banked `translate()` map.
